// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter command/status bundle.
// master: the command owner (drives tx_valid/tx_data, observes status).
// slave : the transmitter (drives tx_ready/busy/done/ack_ok/err_timeout).
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err_timeout;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, done, ack_ok, err_timeout
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, done, ack_ok, err_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the device.
// Ports: clk/rst_n, tx_if (valid/ready command plus done/ack_ok/err_timeout status),
//        ps2_clk_in/ps2_data_in (raw pins), ps2_clk_oe/ps2_data_oe (1 = pull pin low).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int REQ_CYCLES     = 200,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave tx_if,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam int MAX_AB  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int MAX_CD  = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  // Counters are loaded with N-1 so a phase lasts exactly N cycles,
  // the last of which is the cycle the counter reads 0.
  localparam logic [CW-1:0] L_INH   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] L_REQ   = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] L_START = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] L_XFER  = CW'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit_idx;   // number of device falling edges seen in SEND
  logic [7:0]    r_data;
  logic          r_parity;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_done;
  logic          r_ack_ok;
  logic          r_err;

  logic          r_clk_s1, r_clk_s2, r_clk_prev;
  logic          r_dat_s1, r_dat_s2;

  logic          w_fall;
  logic          w_cnt_zero;
  logic [CW-1:0] w_cnt_dec;
  logic [15:0]   w_frame;

  // Pins idle high, so the synchronizers reset to 1 and no edge is seen out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall     = r_clk_prev & ~r_clk_s2;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_dec  = w_cnt_zero ? '0 : r_cnt - CW'(1);
  // Frame bits in send order, indexed by the edge count; upper padding reads as released.
  assign w_frame    = {6'h3F, 1'b1, r_parity, r_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_ack_ok  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (tx_if.tx_valid) begin
            r_data   <= tx_if.tx_data;
            r_parity <= ~^tx_if.tx_data;
            r_ack_ok <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= L_INH;
            r_clk_oe <= 1'b1;
            r_state  <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (w_cnt_zero) begin
            r_data_oe <= 1'b1;           // start bit
            r_cnt     <= L_REQ;
            r_state   <= S_REQ;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        S_REQ: begin
          if (w_cnt_zero) begin
            r_clk_oe  <= 1'b0;           // hand the clock to the device
            r_bit_idx <= '0;
            r_cnt     <= L_START;
            r_state   <= S_SEND;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        S_SEND: begin
          // The ACK edge beats a coincident timeout; any other edge loses to it.
          if (w_fall && (r_bit_idx == 4'd10)) begin
            r_ack_ok  <= ~r_dat_s2;
            r_data_oe <= 1'b0;
            r_cnt     <= w_cnt_dec;
            r_state   <= S_WAIT_IDLE;
          end else if (w_cnt_zero) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_ack_ok  <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_fall) begin
            r_data_oe <= ~w_frame[r_bit_idx];
            r_bit_idx <= r_bit_idx + 4'd1;
            // First device edge ends the start wait and opens the transfer window.
            r_cnt     <= (r_bit_idx == 4'd0) ? L_XFER : w_cnt_dec;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        S_WAIT_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (r_clk_s2 && r_dat_s2) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_cnt_zero) begin
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_ack_ok <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ps2_clk_oe        = r_clk_oe;
  assign ps2_data_oe       = r_data_oe;
  assign tx_if.tx_ready    = (r_state == S_IDLE);
  assign tx_if.busy        = (r_state != S_IDLE);
  assign tx_if.done        = r_done;
  assign tx_if.ack_ok      = r_ack_ok;
  assign tx_if.err_timeout = r_err;
endmodule
